// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
package sram_arbiter_pkg;

   localparam int SRAM_ADDR_W = 14;
   localparam int SRAM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IF_RD = 2'd1,
      DM_RD = 2'd2,
      DM_WR = 2'd3
   } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive DM grants taken while IF waits, and raises force_if once the
// instruction side has waited the maximum number of grants.
module arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic if_gnt,
   input  logic dm_gnt,
   output logic force_if
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (!if_req || if_gnt) begin
         cnt_d = '0;
      end else if (dm_gnt && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_if = if_req && (cnt_q == CNT_MAX);

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a single-port SRAM: DM has priority, IF is forced in
// after STARVE_MAX consecutive DM wins. Define ARB_PERF_CNT_EN to add grant/stall counters.
//
//   state | meaning
//   IDLE  | no response due this cycle
//   IF_RD | sram_do carries the fetch read data
//   DM_RD | sram_do carries the data read data
//   DM_WR | write landed at the grant edge, nothing to return
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W     = SRAM_ADDR_W,
   parameter int STARVE_MAX = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_req,
   input  logic [ADDR_W-1:0]      if_addr,
   output logic                   if_gnt,
   output logic                   if_rvalid,
   output logic [SRAM_DATA_W-1:0] if_rdata,
   input  logic                   dm_req,
   input  logic [3:0]             dm_we,
   input  logic [ADDR_W-1:0]      dm_addr,
   input  logic [SRAM_DATA_W-1:0] dm_wdata,
   output logic                   dm_gnt,
   output logic                   dm_rvalid,
   output logic [SRAM_DATA_W-1:0] dm_rdata,
   output logic                   sram_cs,
   output logic [3:0]             sram_we,
   output logic [ADDR_W-1:0]      sram_a,
   output logic [SRAM_DATA_W-1:0] sram_di,
   input  logic [SRAM_DATA_W-1:0] sram_do
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]            perf_if_gnt,
   output logic [31:0]            perf_dm_gnt,
   output logic [31:0]            perf_if_stall
`endif
);

   arb_state_e state_d, state_q;
   logic       force_if;

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_gnt   (if_gnt),
      .dm_gnt   (dm_gnt),
      .force_if (force_if)
   );

   // Grants are held off while reset is asserted so nothing reaches the SRAM.
   always_comb begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
      if (rst) begin
         if_gnt = if_req && (!dm_req || force_if);
         dm_gnt = dm_req && !if_gnt;
      end
   end

   always_comb begin
      sram_cs = 1'b0;
      sram_we = 4'b0000;
      sram_a  = '0;
      sram_di = '0;
      state_d = IDLE;
      if (if_gnt) begin
         sram_cs = 1'b1;
         sram_a  = if_addr;
         state_d = IF_RD;
      end else if (dm_gnt) begin
         sram_cs = 1'b1;
         sram_we = dm_we;
         sram_a  = dm_addr;
         sram_di = dm_wdata;
         state_d = (dm_we == 4'b0000) ? DM_RD : DM_WR;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      if_rvalid = (state_q == IF_RD);
      dm_rvalid = (state_q == DM_RD);
      if_rdata  = if_rvalid ? sram_do : '0;
      dm_rdata  = dm_rvalid ? sram_do : '0;
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_if_gnt_d, perf_if_gnt_q;
   logic [31:0] perf_dm_gnt_d, perf_dm_gnt_q;
   logic [31:0] perf_if_stall_d, perf_if_stall_q;

   always_comb begin
      perf_if_gnt_d   = perf_if_gnt_q;
      perf_dm_gnt_d   = perf_dm_gnt_q;
      perf_if_stall_d = perf_if_stall_q;
      if (if_gnt) begin
         perf_if_gnt_d = perf_if_gnt_q + 32'd1;
      end
      if (dm_gnt) begin
         perf_dm_gnt_d = perf_dm_gnt_q + 32'd1;
      end
      if (if_req && !if_gnt) begin
         perf_if_stall_d = perf_if_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_if_gnt_q   <= '0;
         perf_dm_gnt_q   <= '0;
         perf_if_stall_q <= '0;
      end else begin
         perf_if_gnt_q   <= perf_if_gnt_d;
         perf_dm_gnt_q   <= perf_dm_gnt_d;
         perf_if_stall_q <= perf_if_stall_d;
      end
   end

   assign perf_if_gnt   = perf_if_gnt_q;
   assign perf_dm_gnt   = perf_dm_gnt_q;
   assign perf_if_stall = perf_if_stall_q;
`endif

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 14, SRAM word-address width (16384 words).
REQ-002 Parameter: STARVE_MAX, 4, maximum consecutive DM grants while IF waits.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 if_req  in  1  instruction-fetch read request; held until if_gnt.
REQ-007 if_addr  in  ADDR_W  fetch word address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid, if_rdata  out  1, 32  fetch read response.
REQ-010 dm_req  in  1  data request; held with stable fields until dm_gnt.
REQ-011 dm_we  in  4  byte write enables; 0 = read.
REQ-012 dm_addr, dm_wdata  in  ADDR_W, 32  data word address and write data.
REQ-013 dm_gnt  out  1  data request accepted this cycle.
REQ-014 dm_rvalid, dm_rdata  out  1, 32  data read response.
REQ-015 sram_cs, sram_we, sram_a, sram_di  out  1, 4, ADDR_W, 32  shared SRAM command.
REQ-016 sram_do  in  32  SRAM read data, valid one cycle after a read command.

Function
REQ-017 Grants SHALL be combinational in the request cycle; at most one of if_gnt/dm_gnt high per cycle.
REQ-018 Default priority SHALL go to DM; IF wins when dm_req is low, or when if_req is high and starve_cnt == STARVE_MAX.
REQ-019 starve_cnt SHALL increment on a DM grant while if_req is high, clear on an IF grant or whenever if_req is low, and saturate at STARVE_MAX.
REQ-020 On any grant, sram_cs SHALL be 1 and sram_a/sram_we/sram_di SHALL carry the winner's fields; IF always drives sram_we = 0. With no grant, sram_cs = 0 and the other SRAM outputs are 0.
REQ-021 The pending-response state register SHALL take one of IDLE, IF_RD, DM_RD, DM_WR, loaded each cycle from the grant: IF_RD for an IF grant, DM_RD or DM_WR by dm_we, IDLE when there is no grant.
REQ-022 In state IF_RD, if_rvalid SHALL be 1 and if_rdata SHALL equal sram_do; in DM_RD, dm_rvalid SHALL be 1 and dm_rdata SHALL equal sram_do. Read latency is exactly 1 cycle after the grant.
REQ-023 DM_WR SHALL produce no response. A write is complete at the grant edge.
REQ-024 A *_rdata output SHALL be 0 whenever its *_rvalid is 0.
REQ-025 Back-to-back grants SHALL be permitted every cycle with no bubbles; a new grant may coincide with the previous response.
REQ-026 Simultaneous requests with starve_cnt < STARVE_MAX SHALL grant DM only; the IF request stays pending.
REQ-027 A requester that drops its req without receiving gnt SHALL be ignored without error.

Reset
REQ-028 While rst = 0: state = IDLE, starve_cnt = 0, all gnt/rvalid/rdata outputs = 0, sram_cs = 0.
REQ-029 A read granted in the cycle before rst asserts SHALL be discarded; no rvalid SHALL appear after rst deasserts.

Configuration
REQ-030 With ARB_PERF_CNT_EN defined, the block SHALL add outputs perf_if_gnt[31:0], perf_dm_gnt[31:0] and perf_if_stall[31:0]. These count IF grants, DM grants, and cycles with if_req high but no if_gnt. They wrap at 2^32 and are cleared by rst.
REQ-031 Without ARB_PERF_CNT_EN, those ports and their counters SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package SHALL hold the arb_state_e enum (IDLE, IF_RD, DM_RD, DM_WR), the SRAM_ADDR_W constant and the SRAM_DATA_W constant.
REQ-033 One sub-module SHALL be used: arb_starve_ctr, which contains the saturating counter and produces the force-IF flag. Everything else stays in sram_arbiter.

Verification
REQ-034 After rst releases, apply if_req with if_addr=0x0010 and SRAM word 0x0010=0x00A00093 -> if_gnt=1 in the same cycle; next cycle if_rvalid=1 and if_rdata=0x00A00093.
REQ-035 Apply dm_req with dm_we=4'b0011, dm_addr=0x3FFF, dm_wdata=0xFFFFFFFF over prior word 0x12345678 -> dm_gnt=1 and no dm_rvalid; a later DM read of 0x3FFF returns 0x1234FFFF.
REQ-036 Hold if_req and dm_req continuously with STARVE_MAX=4 -> grant pattern DM,DM,DM,DM,IF repeating; if_rvalid arrives one cycle after each IF grant.
REQ-037 Hold DM reads of 0x0000..0x0007 back-to-back -> 8 consecutive dm_gnt cycles, then 8 consecutive dm_rvalid cycles with matching data, with zero bubbles.
REQ-038 Grant an IF read, then drive rst=0 in the next half-cycle -> if_rvalid stays 0 through reset and after release; all outputs are 0 during reset.
REQ-039 With ARB_PERF_CNT_EN defined, run REQ-036 for 10 cycles -> perf_dm_gnt=8, perf_if_gnt=2, perf_if_stall=8.
